// File: rtl/mode7_fp_pkg.sv
// rtl/mode7_fp_pkg.sv - shared fixed-point constants and range helpers for the Mode7 datapath
package mode7_fp_pkg;

  localparam int MODE7_FP_WIDTH = 24;
  localparam int MODE7_FP_FRAC  = 8;

  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;

  function automatic logic signed [63:0] fp_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] fp_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/fp_round_sat.sv
// rtl/fp_round_sat.sv - combinational round, shift and range clamp of a double-width signed product
module fp_round_sat
  import mode7_fp_pkg::*;
#(
  parameter int WIDTH    = MODE7_FP_WIDTH,
  parameter int FRAC     = MODE7_FP_FRAC,
  parameter int ROUND    = RND_HALF_UP,
  parameter int SATURATE = 1
) (
  input  logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  // One guard bit so the rounding add can never wrap.
  localparam int EW  = 2 * WIDTH + 1;
  localparam int HSH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [EW-1:0] HALF =
    (ROUND == RND_HALF_UP && FRAC > 0) ? (EW'(1) << HSH) : {EW{1'b0}};
  localparam logic signed [EW-1:0] MAXV = EW'(fp_max(WIDTH));
  localparam logic signed [EW-1:0] MINV = EW'(fp_min(WIDTH));

  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] shifted;

  always_comb begin
    sum      = $signed({prod[2*WIDTH-1], prod}) + HALF;
    shifted  = sum >>> FRAC;
    overflow = (shifted > MAXV) || (shifted < MINV);
    result   = shifted[WIDTH-1:0];
    if (overflow && SATURATE != 0) begin
      result = shifted[EW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/multiply_fp_pipe.sv
// rtl/multiply_fp_pipe.sv - pipelined signed fixed-point multiplier with valid/ready handshake
module multiply_fp_pipe
  import mode7_fp_pkg::*;
#(
  parameter int WIDTH    = MODE7_FP_WIDTH,
  parameter int FRAC     = MODE7_FP_FRAC,
  parameter int STAGES   = 3,
  parameter int ROUND    = RND_HALF_UP,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  localparam int PW   = 2 * WIDTH;
  localparam int PSTG = (STAGES == 4) ? 1 : ((STAGES >= 2) ? STAGES - 2 : 0);

  if (WIDTH < 4 || WIDTH > 32 || FRAC < 0 || FRAC > WIDTH - 1 || STAGES < 1 || STAGES > 4 ||
      (ROUND != RND_TRUNC && ROUND != RND_HALF_UP) || (SATURATE != 0 && SATURATE != 1))
  begin : g_bad_params
    $fatal(1, "multiply_fp_pipe: illegal parameter combination");
  end

  logic              adv;
  logic [STAGES:0]   vin;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]  a_s, b_s;
  logic [PW-1:0]     p_mul, p_s;
  logic [WIDTH-1:0]  res, out_q, out_d;
  logic              res_ovf, ovf_q, ovf_d;

  // vin[k] is the valid bit feeding stage k; vin[STAGES] is the output stage.
  assign vin       = {vld_q, in_valid};
  assign out_valid = vin[STAGES];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign p_mul     = $signed({{WIDTH{a_s[WIDTH-1]}}, a_s}) * $signed({{WIDTH{b_s[WIDTH-1]}}, b_s});

  always_comb begin
    vld_d = vld_q;
    if (adv) vld_d = vin[STAGES-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  if (STAGES >= 3) begin : g_op_reg
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (adv && vin[0]) begin
        a_d = a;
        b_d = b;
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
    assign a_s = a_q;
    assign b_s = b_q;
  end else begin : g_op_pass
    assign a_s = a;
    assign b_s = b;
  end

  if (STAGES >= 2) begin : g_prod_reg
    logic [PW-1:0] p_q, p_d;
    always_comb begin
      p_d = p_q;
      if (adv && vin[PSTG]) p_d = p_mul;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) p_q <= '0;
      else        p_q <= p_d;
    end
    if (STAGES == 4) begin : g_retime
      logic [PW-1:0] pr_q, pr_d;
      always_comb begin
        pr_d = pr_q;
        if (adv && vin[2]) pr_d = p_q;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pr_q <= '0;
        else        pr_q <= pr_d;
      end
      assign p_s = pr_q;
    end else begin : g_no_retime
      assign p_s = p_q;
    end
  end else begin : g_prod_pass
    assign p_s = p_mul;
  end

  fp_round_sat #(
    .WIDTH    (WIDTH),
    .FRAC     (FRAC),
    .ROUND    (ROUND),
    .SATURATE (SATURATE)
  ) u_round_sat (
    .prod     (p_s),
    .result   (res),
    .overflow (res_ovf)
  );

  // Result register only loads real data so out holds its last product across bubbles.
  always_comb begin
    out_d = out_q;
    ovf_d = ovf_q;
    if (adv && vin[STAGES-1]) begin
      out_d = res;
      ovf_d = res_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_multiply_fp_pipe.sv
// tb/tb_multiply_fp_pipe.sv - self-checking bench over several multiply_fp_pipe configurations
module tb_multiply_fp_pipe;

  localparam int N = 5;
  localparam int CFG_ST  [N] = '{3, 1, 2, 4, 2};
  localparam int CFG_RND [N] = '{1, 1, 1, 1, 0};
  localparam int CFG_SAT [N] = '{1, 1, 1, 1, 0};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid  [N];
  logic        in_ready  [N];
  logic [23:0] a_v       [N];
  logic [23:0] b_v       [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic [23:0] out_v     [N];
  logic        ovf_v     [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    multiply_fp_pipe #(
      .WIDTH(24), .FRAC(8), .STAGES(CFG_ST[g]), .ROUND(CFG_RND[g]), .SATURATE(CFG_SAT[g])
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .a(a_v[g]), .b(b_v[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out(out_v[g]), .overflow(ovf_v[g])
    );
  end

  function automatic void model(input int k, input logic [23:0] av, input logic [23:0] bv,
                                output logic [23:0] o, output logic ov);
    longint p, s;
    p = longint'($signed(av)) * longint'($signed(bv));
    if (CFG_RND[k] != 0) p += 128;
    s  = p >>> 8;
    ov = (s > 64'sd8388607) || (s < -64'sd8388608);
    if (ov && CFG_SAT[k] != 0) o = (s < 0) ? 24'h800000 : 24'h7FFFFF;
    else                       o = s[23:0];
  endfunction

  // Present one op in the current cycle, return edges until out_valid and the result.
  task automatic do_op(input int k, input logic [23:0] av, input logic [23:0] bv,
                       output int lat, output logic [23:0] o, output logic ov);
    in_valid[k]  = 1'b1;
    a_v[k]       = av;
    b_v[k]       = bv;
    out_ready[k] = 1'b1;
    lat = -1;
    o   = '0;
    ov  = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      if (out_valid[k]) begin
        lat = c;
        o   = out_v[k];
        ov  = ovf_v[k];
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (out_valid[k] !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b want 0", k, out_valid[k]); end
      n_cmp++; if (out_v[k] !== 24'h0) begin n_bad++; $display("FAIL reset_out[%0d]: got %h want 000000", k, out_v[k]); end
      n_cmp++; if (ovf_v[k] !== 1'b0) begin n_bad++; $display("FAIL reset_ovf[%0d]: got %b want 0", k, ovf_v[k]); end
      n_cmp++; if (in_ready[k] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, in_ready[k]); end
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [23:0] o; logic ov;
    do_op(0, 24'h000180, 24'h000200, lat, o, ov);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL basic_latency: got %0d want 3", lat); end
    n_cmp++; if (o !== 24'h000300) begin n_bad++; $display("FAIL basic_out: got %h want 000300", o); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", ov); end
  endtask

  task automatic test_negative();
    int lat; logic [23:0] o; logic ov;
    do_op(0, 24'hFFFE80, 24'h000200, lat, o, ov);
    n_cmp++; if (o !== 24'hFFFD00) begin n_bad++; $display("FAIL neg_pos_out: got %h want FFFD00", o); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL neg_pos_ovf: got %b want 0", ov); end
    do_op(0, 24'hFFFE80, 24'hFFFE80, lat, o, ov);
    n_cmp++; if (o !== 24'h000240) begin n_bad++; $display("FAIL neg_neg_out: got %h want 000240", o); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL neg_neg_ovf: got %b want 0", ov); end
  endtask

  task automatic test_latency();
    int lat; logic [23:0] o; logic ov;
    for (int k = 0; k < N; k++) begin
      do_op(k, 24'h000180, 24'h000200, lat, o, ov);
      n_cmp++; if (lat !== CFG_ST[k]) begin n_bad++; $display("FAIL latency[%0d]: got %0d want %0d", k, lat, CFG_ST[k]); end
      n_cmp++; if (o !== 24'h000300) begin n_bad++; $display("FAIL latency_out[%0d]: got %h want 000300", k, o); end
    end
  endtask

  task automatic test_rounding();
    int          tk  [4] = '{0, 4, 0, 4};
    logic [23:0] ta  [4] = '{24'h000001, 24'h000001, 24'hFFFFFF, 24'hFFFFFF};
    logic [23:0] tbv [4] = '{24'h000080, 24'h000080, 24'h000080, 24'h000080};
    logic [23:0] te  [4] = '{24'h000001, 24'h000000, 24'h000000, 24'hFFFFFF};
    int lat; logic [23:0] o; logic ov;
    for (int i = 0; i < 4; i++) begin
      do_op(tk[i], ta[i], tbv[i], lat, o, ov);
      n_cmp++; if (o !== te[i]) begin n_bad++; $display("FAIL round_out[%0d]: got %h want %h", i, o, te[i]); end
      n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL round_ovf[%0d]: got %b want 0", i, ov); end
    end
  endtask

  task automatic test_saturation();
    int          tk  [6] = '{0, 0, 0, 4, 0, 4};
    logic [23:0] ta  [6] = '{24'h7FFFFF, 24'h800000, 24'h800000, 24'h7FFFFF, 24'h07FF80, 24'h07FF80};
    logic [23:0] tbv [6] = '{24'h7FFFFF, 24'h800000, 24'h000100, 24'h7FFFFF, 24'h001001, 24'h001001};
    logic [23:0] te  [6] = '{24'h7FFFFF, 24'h7FFFFF, 24'h800000, 24'hFF0000, 24'h7FFFFF, 24'h7FFFFF};
    logic        tv  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat; logic [23:0] o; logic ov;
    for (int i = 0; i < 6; i++) begin
      do_op(tk[i], ta[i], tbv[i], lat, o, ov);
      n_cmp++; if (o !== te[i]) begin n_bad++; $display("FAIL sat_out[%0d]: got %h want %h", i, o, te[i]); end
      n_cmp++; if (ov !== tv[i]) begin n_bad++; $display("FAIL sat_ovf[%0d]: got %b want %b", i, ov, tv[i]); end
    end
  endtask

  // Stream nops random ops; stall_mode holds out_ready low 5 cycles after first out_valid.
  task automatic stream(input int k, input int nops, input bit stall_mode);
    logic [23:0] eq_o [$];
    logic        eq_v [$];
    logic [23:0] eo, held_o;
    logic        ev, held, held_ov;
    int sent = 0, got = 0, stall = -1, cyc = 0, extra = 0;
    held = 1'b0; held_o = '0; held_ov = 1'b0;
    while (got < nops && cyc < nops * 12 + 100) begin
      if (held) begin
        n_cmp++;
        if (out_valid[k] !== 1'b1 || out_v[k] !== held_o || ovf_v[k] !== held_ov) begin
          n_bad++;
          $display("FAIL stall_hold[%0d]: got v=%b %h/%b want v=1 %h/%b", k, out_valid[k], out_v[k], ovf_v[k], held_o, held_ov);
        end
      end
      if (stall_mode) begin
        if (stall < 0 && out_valid[k]) stall = 5;
        if (stall > 0) begin out_ready[k] = 1'b0; stall--; end
        else out_ready[k] = 1'b1;
      end else begin
        out_ready[k] = 1'($urandom_range(0, 1));
      end
      in_valid[k] = (sent < nops) && (stall_mode || $urandom_range(0, 3) != 0);
      a_v[k] = 24'($urandom);
      b_v[k] = 24'($urandom);
      #1;
      if (out_valid[k] && !out_ready[k]) begin
        n_cmp++; if (in_ready[k] !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, in_ready[k]); end
      end
      if (in_valid[k] && in_ready[k]) begin
        model(k, a_v[k], b_v[k], eo, ev);
        eq_o.push_back(eo);
        eq_v.push_back(ev);
        sent++;
      end
      if (out_valid[k] && out_ready[k]) begin
        n_cmp++;
        if (eq_o.size() == 0) begin
          n_bad++; $display("FAIL stream_spurious[%0d]: got %h want no output", k, out_v[k]);
        end else begin
          eo = eq_o.pop_front();
          ev = eq_v.pop_front();
          if (out_v[k] !== eo || ovf_v[k] !== ev) begin
            n_bad++; $display("FAIL stream_data[%0d] #%0d: got %h/%b want %h/%b", k, got, out_v[k], ovf_v[k], eo, ev);
          end
        end
        got++;
      end
      held    = out_valid[k] && !out_ready[k];
      held_o  = out_v[k];
      held_ov = ovf_v[k];
      @(posedge clk); #1;
      cyc++;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    n_cmp++; if (got !== nops) begin n_bad++; $display("FAIL stream_count[%0d]: got %0d want %0d", k, got, nops); end
    for (int c = 0; c < 6; c++) begin
      if (out_valid[k]) extra++;
      @(posedge clk); #1;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL stream_extra[%0d]: got %0d want 0", k, extra); end
  endtask

  task automatic test_backpressure();
    stream(0, 8, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < N; k++) stream(k, 1000, 1'b0);
  endtask

  task automatic test_reset_midstream();
    int lat, seen; logic [23:0] o; logic ov;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[0] = 1'b1;
      a_v[0] = (i == 0) ? 24'h7FFFFF : 24'h000180;
      b_v[0] = (i == 0) ? 24'h7FFFFF : 24'h000200;
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    n_cmp++; if (out_valid[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", out_valid[0]); end
    n_cmp++; if (out_v[0] !== 24'h0) begin n_bad++; $display("FAIL midrst_out: got %h want 000000", out_v[0]); end
    n_cmp++; if (ovf_v[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_ovf: got %b want 0", ovf_v[0]); end
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid[0]) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_stale: got %0d valid cycles want 0", seen); end
    do_op(0, 24'h000180, 24'h000300, lat, o, ov);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL midrst_latency: got %0d want 3", lat); end
    n_cmp++; if (o !== 24'h000480) begin n_bad++; $display("FAIL midrst_out_after: got %h want 000480", o); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      in_valid[k]  = 1'b0;
      a_v[k]       = '0;
      b_v[k]       = '0;
      out_ready[k] = 1'b1;
    end
    test_reset();
    test_basic();
    test_negative();
    test_latency();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multiply_fp_pipe.md
Name: multiply_fp_pipe

Overview:
Parametrised, pipelined, signed fixed-point multiplier for the Mode7 affine datapath, replacing the combinational multiply_fp. It computes a*b in a Q(WIDTH-FRAC).FRAC format with selectable rounding and saturation. A valid/ready handshake on both sides lets the address generator stream one product per clock and absorb downstream stalls.

Parameters:
WIDTH, 24, operand and result width in bits (two's complement); legal 4..32
FRAC, 8, fractional bits; legal 0..WIDTH-1
STAGES, 3, pipeline depth = latency in cycles with no stall; legal 1..4
ROUND, 1, 0 = truncate (floor toward -inf); 1 = round half up (add 2^(FRAC-1) before shift)
SATURATE, 1, 1 = clamp to signed WIDTH range on overflow; 0 = wrap (keep low WIDTH bits)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands a/b present
in_ready  out  1  block accepts operands this cycle
a  in  WIDTH  multiplicand, signed fixed-point
b  in  WIDTH  multiplier, signed fixed-point
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
out  out  WIDTH  product, signed fixed-point
overflow  out  1  result exceeded representable range; qualified by out_valid

Behaviour:
- Reset (async, rst_n low): all stage valid bits 0; out, overflow and every data register 0. In-flight operations are discarded and never emitted. First acceptance is possible on the first rising edge after rst_n releases.
- Global advance: adv = out_ready | ~out_valid. in_ready = adv, combinational. All stages shift together when adv=1; all stages hold when adv=0. Bubbles are not collapsed.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Latency: exactly STAGES cycles from input transfer to out_valid when no stall. Throughput is 1 per cycle. Order is preserved. No drop or duplication under any out_ready pattern.
- While out_valid=1 and out_ready=0, out and overflow hold stable.
- Arithmetic:
  - Full product p = signed(a)*signed(b), 2*WIDTH bits.
  - If ROUND=1 and FRAC>0, compute p + 2^(FRAC-1).
  - Arithmetic shift right by FRAC.
  - Compare the shifted result against [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Out of range sets overflow=1.
  - Out of range with SATURATE=1: clamp to 0x7F..F or 0x80..0.
  - Out of range with SATURATE=0: low WIDTH bits, overflow still flagged.
- Rounding is evaluated before range check, so 0x7FFFFF.xx rounding up overflows.
- Stage mapping (each "reg" is a pipeline register with a valid bit):
  - STAGES=1: multiply+round+sat -> reg.
  - STAGES=2: product reg -> round/sat reg.
  - STAGES=3: operand reg -> product reg -> round/sat reg.
  - STAGES=4: operand reg -> product reg -> product retime reg -> round/sat reg.
- Illegal parameters: an elaboration-time assertion stops simulation.

Decomposition:
- Package mode7_fp_pkg:
  - MODE7_FP_WIDTH=24, MODE7_FP_FRAC=8
  - round-mode localparams RND_TRUNC=0, RND_HALF_UP=1
  - function fp_max/fp_min(width)
- Sub-module fp_round_sat: purely combinational; parameters WIDTH, FRAC, ROUND, SATURATE; input 2*WIDTH product; outputs WIDTH result and overflow. It is reusable by a later adder/MAC.
- The pipeline, valid bits and handshake live in multiply_fp_pipe.

Test Plan:
1. Defaults; a=0x000180 (1.5), b=0x000200 (2.0), out_ready=1 -> out=0x000300, overflow=0, out_valid exactly 3 cycles after transfer.
2. Negative operand: a=0xFFFE80 (-1.5), b=0x000200 -> out=0xFFFD00; a=0xFFFE80, b=0xFFFE80 -> 0x000240 (2.25).
3. Rounding: a=0x000001, b=0x000080 (half LSB) -> out=0x000001 with ROUND=1, 0x000000 with ROUND=0. a=0xFFFFFF, b=0x000080 -> 0x000000 with ROUND=1, 0xFFFFFF with ROUND=0.
4. Saturation:
   - a=b=0x7FFFFF -> out=0x7FFFFF, overflow=1.
   - a=b=0x800000 -> 0x7FFFFF, overflow=1.
   - a=0x800000, b=0x000100 -> 0x800000, overflow=0.
   - With SATURATE=0, a=b=0x7FFFFF -> low 24 bits of the shifted product, overflow=1.
5. Backpressure: stream 8 random ops back to back, hold out_ready=0 for 5 cycles after first out_valid -> in_ready=0 during stall, out stable, all 8 results emitted in order matching the reference model. Repeat with random out_ready for 1000 ops, all STAGES values 1..4.
6. Reset mid-stream: drop rst_n with 2 ops in flight, asynchronous to clk -> out_valid=0 and out=0 immediately. After release, no stale results appear and the next op completes with normal latency.
